fp_mult_arbiter: RTL and testbench

Shares one pipelined single-precision multiplier (fp_mult_sp) among NUM_REQ requesters.
- Arbitrates operand requests round-robin, one issue per cycle.
- Tracks requester tags alongside the multiplier's fixed latency and returns each result, with status flags, to its originator.
- Provides a halt/drain handshake so software or a sequencer can quiesce the unit.

---
 rtl/fp_mult_arb_pkg.sv | 20 ++
 rtl/fp_mult_sp.sv | 103 ++++++++++
 rtl/fp_rr_arbiter.sv | 53 +++++
 rtl/fp_mult_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fp_mult_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mult_arb_pkg.sv
// Shared definitions for the fp_mult_arbiter block: operand width, result flag bit
// positions, grant counter width and the quiesce FSM state encoding.
package fp_mult_arb_pkg;

    localparam int unsigned FP_WIDTH        = 32;
    localparam int unsigned GRANT_CNT_WIDTH = 16;

    // Bit positions within the 4-bit result flag vector {INF, NaN, DENORMAL, ZERO}
    localparam int unsigned FLAG_INF      = 3;
    localparam int unsigned FLAG_NAN      = 2;
    localparam int unsigned FLAG_DENORMAL = 1;
    localparam int unsigned FLAG_ZERO     = 0;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fp_mult_sp.sv
// Pipelined IEEE-754 single-precision multiplier, LATENCY clocks from i_A/i_B to o_RES/o_FLAGS.
// Denormal operands are treated as zero; results that would be subnormal are flushed to a
// signed zero with DENORMAL and ZERO flagged. Round to nearest even. Pipeline is not reset.
// Ports: i_CLK clock; i_A, i_B operands; o_RES product; o_FLAGS {INF, NaN, DENORMAL, ZERO}.
module fp_mult_sp
    import fp_mult_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 5
) (
    input  logic                i_CLK,
    input  logic [FP_WIDTH-1:0] i_A,
    input  logic [FP_WIDTH-1:0] i_B,
    output logic [FP_WIDTH-1:0] o_RES,
    output logic [3:0]          o_FLAGS
);

    logic                sign;
    logic [7:0]          ea, eb;
    logic [22:0]         ma, mb;
    logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]         prod;
    logic signed [9:0]   exp_s, exp_r;
    logic [22:0]         mant;
    logic                guard, sticky, rnd_up;
    logic [32:0]         em;
    logic [FP_WIDTH-1:0] res_c;
    logic [3:0]          flg_c;
    logic [FP_WIDTH+3:0] pipe_q [LATENCY];

    assign sign   = i_A[31] ^ i_B[31];
    assign ea     = i_A[30:23];
    assign eb     = i_B[30:23];
    assign ma     = i_A[22:0];
    assign mb     = i_B[22:0];
    assign a_nan  = (ea == 8'hFF) && (ma != 23'h0);
    assign b_nan  = (eb == 8'hFF) && (mb != 23'h0);
    assign a_inf  = (ea == 8'hFF) && (ma == 23'h0);
    assign b_inf  = (eb == 8'hFF) && (mb == 23'h0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    always_comb begin
        res_c  = '0;
        flg_c  = '0;
        prod   = '0;
        exp_s  = '0;
        exp_r  = '0;
        mant   = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        rnd_up = 1'b0;
        em     = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            res_c           = 32'h7FC0_0000;
            flg_c[FLAG_NAN] = 1'b1;
        end else if (a_inf || b_inf) begin
            res_c           = {sign, 8'hFF, 23'h0};
            flg_c[FLAG_INF] = 1'b1;
        end else if (a_zero || b_zero) begin
            res_c            = {sign, 31'h0};
            flg_c[FLAG_ZERO] = 1'b1;
        end else begin
            prod  = 48'({1'b1, ma}) * 48'({1'b1, mb});
            exp_s = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
            // Product of two [1,2) significands lies in [1,4): normalise by at most one bit
            if (prod[47]) begin
                exp_s  = exp_s + 10'sd1;
                mant   = prod[46:24];
                guard  = prod[23];
                sticky = |prod[22:0];
            end else begin
                mant   = prod[45:23];
                guard  = prod[22];
                sticky = |prod[21:0];
            end
            rnd_up = guard & (sticky | mant[0]);
            // Rounding carry out of the mantissa propagates straight into the exponent
            em    = {exp_s, mant} + {32'h0, rnd_up};
            exp_r = $signed(em[32:23]);
            if (exp_r >= 10'sd255) begin
                res_c           = {sign, 8'hFF, 23'h0};
                flg_c[FLAG_INF] = 1'b1;
            end else if (exp_r <= 10'sd0) begin
                res_c                = {sign, 31'h0};
                flg_c[FLAG_DENORMAL] = 1'b1;
                flg_c[FLAG_ZERO]     = 1'b1;
            end else begin
                res_c = {sign, em[30:23], em[22:0]};
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        pipe_q[0] <= {flg_c, res_c};
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign o_RES   = pipe_q[LATENCY-1][FP_WIDTH-1:0];
    assign o_FLAGS = pipe_q[LATENCY-1][FP_WIDTH+3:FP_WIDTH];

endmodule

// File: rtl/fp_rr_arbiter.sv
// Round-robin arbiter: searches i_VALID starting at the pointer, wrapping at NUM_REQ-1 -> 0.
// After a grant to k the pointer moves to (k+1) mod NUM_REQ; otherwise it holds.
// Ports: i_CLK, i_RST (async, active high); i_EN gates all grants; i_VALID requests;
// o_GRANT one-hot grant; o_GRANT_IDX / o_GRANT_VLD encoded grant.
module fp_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_EN,
    input  logic [NUM_REQ-1:0] i_VALID,
    output logic [NUM_REQ-1:0] o_GRANT,
    output logic [IDX_W-1:0]   o_GRANT_IDX,
    output logic               o_GRANT_VLD
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned c;
        o_GRANT     = '0;
        o_GRANT_IDX = '0;
        o_GRANT_VLD = 1'b0;
        c           = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            c = (32'(ptr_q) + i) % NUM_REQ;
            if (i_EN && !o_GRANT_VLD && i_VALID[c]) begin
                o_GRANT_VLD = 1'b1;
                o_GRANT_IDX = IDX_W'(c);
            end
        end
        if (o_GRANT_VLD) begin
            o_GRANT[o_GRANT_IDX] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (o_GRANT_VLD) begin
            ptr_d = (o_GRANT_IDX == IDX_W'(NUM_REQ - 1)) ? '0 : o_GRANT_IDX + IDX_W'(1);
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined fp_mult_sp among NUM_REQ requesters. Round-robin issue (one per cycle),
// a MULT_LAT-deep tag pipe that routes each result back to its issuer, an in-flight counter
// and a RUN/DRAIN/HALTED quiesce FSM driven by i_HALT.
// Ports: i_CLK, i_RST (async, active high); i_REQ_VALID/o_REQ_READY/i_REQ_A/i_REQ_B request
// side (operands packed 32 bits per requester); o_RES_VALID/o_RES/o_RES_FLAGS result side;
// i_HALT/o_HALTED quiesce handshake; o_BUSY operations in flight.
// Optional: define FP_MULT_ARB_PERF_EN to add per-requester 16-bit saturating grant counters
// (o_GRANT_CNT, cleared by i_CNT_CLR).
module fp_mult_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MULT_LAT = 5
) (
    input  logic                        i_CLK,
    input  logic                        i_RST,
    input  logic [NUM_REQ-1:0]          i_REQ_VALID,
    output logic [NUM_REQ-1:0]          o_REQ_READY,
    input  logic [NUM_REQ*FP_WIDTH-1:0] i_REQ_A,
    input  logic [NUM_REQ*FP_WIDTH-1:0] i_REQ_B,
    output logic [NUM_REQ-1:0]          o_RES_VALID,
    output logic [FP_WIDTH-1:0]         o_RES,
    output logic [3:0]                  o_RES_FLAGS,
`ifdef FP_MULT_ARB_PERF_EN
    output logic [NUM_REQ*GRANT_CNT_WIDTH-1:0] o_GRANT_CNT,
    input  logic                        i_CNT_CLR,
`endif
    input  logic                        i_HALT,
    output logic                        o_HALTED,
    output logic                        o_BUSY
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MULT_LAT + 1);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MULT_LAT-1:0] tag_vld_q;
    logic [IDX_W-1:0]    tag_idx_q [MULT_LAT];
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_vld;
    logic                arb_en;
    logic                res_vld;
    logic [FP_WIDTH-1:0] op_a_q, op_b_q, mult_a, mult_b;

    assign arb_en  = (state_q == StRun) && !i_HALT;
    assign res_vld = tag_vld_q[MULT_LAT-1];

    fp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_EN        (arb_en),
        .i_VALID     (i_REQ_VALID),
        .o_GRANT     (grant),
        .o_GRANT_IDX (grant_idx),
        .o_GRANT_VLD (grant_vld)
    );

    assign o_REQ_READY = grant;

    // Operands reach the multiplier in the grant cycle; idle cycles replay the last pair.
    always_comb begin
        mult_a = op_a_q;
        mult_b = op_b_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                mult_a = i_REQ_A[k*FP_WIDTH +: FP_WIDTH];
                mult_b = i_REQ_B[k*FP_WIDTH +: FP_WIDTH];
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        op_a_q <= mult_a;
        op_b_q <= mult_b;
    end

    fp_mult_sp #(
        .LATENCY (MULT_LAT)
    ) u_mult (
        .i_CLK   (i_CLK),
        .i_A     (mult_a),
        .i_B     (mult_b),
        .o_RES   (o_RES),
        .o_FLAGS (o_RES_FLAGS)
    );

    // Tag pipe runs in lockstep with the multiplier; its reset masks stale multiplier data.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            tag_vld_q <= '0;
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= grant_vld;
            tag_idx_q[0] <= grant_idx;
            for (int unsigned i = 1; i < MULT_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    always_comb begin
        o_RES_VALID = '0;
        if (res_vld) begin
            o_RES_VALID[tag_idx_q[MULT_LAT-1]] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({grant_vld, res_vld})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign o_BUSY   = (cnt_q != '0);
    assign o_HALTED = (state_q == StHalted);

    // DRAIN looks at the next count so HALTED follows the final result by exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (i_HALT) state_d = StDrain;
            end
            StDrain: begin
                if (!i_HALT)          state_d = StRun;
                else if (cnt_d == '0) state_d = StHalted;
            end
            StHalted: begin
                if (!i_HALT) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FP_MULT_ARB_PERF_EN
    logic [GRANT_CNT_WIDTH-1:0] gcnt_q [NUM_REQ];

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) gcnt_q[k] <= '0;
        end else if (i_CNT_CLR) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) gcnt_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (grant[k] && (gcnt_q[k] != '1)) begin
                    gcnt_q[k] <= gcnt_q[k] + GRANT_CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        o_GRANT_CNT = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            o_GRANT_CNT[k*GRANT_CNT_WIDTH +: GRANT_CNT_WIDTH] = gcnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
module tb_fp_mult_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*32-1:0] req_a, req_b;
    logic [NR-1:0]   res_valid;
    logic [31:0]     res;
    logic [3:0]      res_flags;
    logic            halt, halted, busy;
`ifdef FP_MULT_ARB_PERF_EN
    logic [NR*16-1:0] grant_cnt;
    logic            cnt_clr;
`endif

    fp_mult_arbiter #(
        .NUM_REQ  (NR),
        .MULT_LAT (LAT)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_REQ_VALID (req_valid),
        .o_REQ_READY (req_ready),
        .i_REQ_A     (req_a),
        .i_REQ_B     (req_b),
        .o_RES_VALID (res_valid),
        .o_RES       (res),
        .o_RES_FLAGS (res_flags),
`ifdef FP_MULT_ARB_PERF_EN
        .o_GRANT_CNT (grant_cnt),
        .i_CNT_CLR   (cnt_clr),
`endif
        .i_HALT      (halt),
        .o_HALTED    (halted),
        .o_BUSY      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic [3:0]  flg;
        int          due;
    } sb_t;

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[9];
    logic [31:0] exp_res [NR];
    logic [3:0]  exp_flg [NR];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_ptr = 0;
    int          last_res_cyc = -1;
    int          smp_cyc = 0;
    logic        hold_valid = 1'b0;
    logic        chk_arb = 1'b0;
    logic [NR-1:0] granted;
    logic [NR-1:0] ready_smp, res_valid_smp;
    logic        halted_smp, busy_smp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observe outputs on the falling edge: result scoreboard, RR model, transfer capture.
    task automatic sample();
        logic [NR-1:0] exp_gnt;
        int c;
        sb_t e;
        smp_cyc       = cyc;
        ready_smp     = req_ready;
        res_valid_smp = res_valid;
        halted_smp    = halted;
        busy_smp      = busy;
        granted       = req_valid & req_ready;
        if (chk_arb) begin
            exp_gnt = '0;
            for (int i = 0; i < NR; i++) begin
                c = (exp_ptr + i) % NR;
                if (exp_gnt == '0 && req_valid[c]) exp_gnt[c] = 1'b1;
            end
            chk("rr_grant", req_ready, exp_gnt);
        end
        if (res_valid !== '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got res_valid %b expected none", res_valid);
            end else begin
                e = sb.pop_front();
                chk("res_valid", res_valid, 4'b0001 << e.idx);
                chk("res_value", res, e.res);
                chk("res_flags", res_flags, e.flg);
                chk("res_latency", cyc, e.due);
                last_res_cyc = cyc;
            end
        end
        for (int k = 0; k < NR; k++) begin
            if (granted[k]) begin
                e.idx = k;
                e.res = exp_res[k];
                e.flg = exp_flg[k];
                e.due = cyc + LAT;
                sb.push_back(e);
                exp_ptr = (k + 1) % NR;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
        if (!hold_valid) req_valid = req_valid & ~granted;
    endtask

    task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [3:0] f);
        req_a[k*32 +: 32] = a;
        req_b[k*32 +: 32] = b;
        exp_res[k] = r;
        exp_flg[k] = f;
    endtask

    task automatic wait_all_granted();
        int n = 0;
        while (req_valid != '0 && n < 12) begin
            step();
            n++;
        end
        if (req_valid != '0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got pending %b expected none", req_valid);
            req_valid = '0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #2_000_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int halt_cyc;
        rst = 1'b1; halt = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
`ifdef FP_MULT_ARB_PERF_EN
        cnt_clr = 1'b0;
`endif
        for (int k = 0; k < NR; k++) set_ops(k, 32'h0, 32'h0, 32'h0, 4'h1);

        vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 4'b0000};
        vecs[1] = '{2, 32'h4040_0000, 32'hC000_0000, 32'hC0C0_0000, 4'b0000};
        vecs[2] = '{1, 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 4'b1000};
        vecs[3] = '{3, 32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 4'b0001};
        vecs[4] = '{0, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b0100};
        vecs[5] = '{1, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0100};
        vecs[6] = '{3, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000};
        vecs[7] = '{2, 32'h3F00_0000, 32'h4080_0000, 32'h4000_0000, 4'b0000};
        vecs[8] = '{0, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b1000};

        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_ready", ready_smp, 0);
        chk("rst_res_valid", res_valid_smp, 0);
        chk("rst_halted", halted_smp, 0);
        chk("rst_busy", busy_smp, 0);

        // Table of single issues, one after another, results pipelined behind
        chk_arb = 1'b1;
        for (int v = 0; v < 9; v++) begin
            set_ops(vecs[v].k, vecs[v].a, vecs[v].b, vecs[v].res, vecs[v].flg);
            req_valid[vecs[v].k] = 1'b1;
            wait_all_granted();
        end
        drain(LAT + 3);

        // All requesters continuously valid: one grant per cycle in rotation
        for (int k = 0; k < NR; k++) set_ops(k, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'h0);
        hold_valid = 1'b1;
        req_valid  = '1;
        for (int i = 0; i < 12; i++) step();
        hold_valid = 1'b0;
        req_valid  = '0;
        drain(LAT + 3);

        // Three in flight, then halt: no grants, HALTED the cycle after the last result
        for (int k = 0; k < NR; k++) set_ops(k, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 4'h0);
        req_valid = 4'b0111;
        wait_all_granted();
        chk_arb = 1'b0;
        halt = 1'b1;
        req_valid[3] = 1'b1;
        halt_cyc = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("halt_no_ready", ready_smp, 0);
            if (halt_cyc < 0 && halted_smp) halt_cyc = smp_cyc;
        end
        chk("halt_timing", halt_cyc, last_res_cyc + 1);
        chk("halt_halted", halted_smp, 1);
        chk("halt_busy", busy_smp, 0);
        chk("halt_sb_empty", sb.size(), 0);
        halt = 1'b0;
        step();
        chk("resume_wait", ready_smp, 0);
        chk("resume_halted_drop", halted_smp, 1);
        step();
        chk("resume_ready", ready_smp, 4'b1000);
        chk("resume_halted", halted_smp, 0);
        drain(LAT + 3);

        // Reset two cycles after two issues: their results must never appear
        chk_arb = 1'b1;
        req_valid = 4'b0011;
        wait_all_granted();
        step();
        step();
        rst = 1'b1;
        sb.delete();
        exp_ptr = 0;
        req_valid = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_res_valid", res_valid_smp, 0);
            chk("post_rst_busy", busy_smp, 0);
        end
        // Pointer restarts at requester 0
        req_valid = 4'b1010;
        step();
        chk("post_rst_grant", ready_smp, 4'b0010);
        req_valid = '0;
        drain(LAT + 3);

`ifdef FP_MULT_ARB_PERF_EN
        chk_arb = 1'b0;
        hold_valid = 1'b1;
        req_valid = 4'b0010;
        for (int i = 0; i < 70000; i++) step();
        hold_valid = 1'b0;
        req_valid = '0;
        drain(LAT + 3);
        chk("perf_saturate", grant_cnt[31:16], 16'hFFFF);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        step();
        chk("perf_clear", grant_cnt[31:16], 16'h0000);
`endif

        chk("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
